// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end: legal transform lengths,
// sequencer state encoding and small helpers for frame length and the
// FFT core's config word.
package fft_pkg;

  localparam int NFFT_MIN    = 7;
  localparam int NFFT_MAX    = 10;
  localparam int CFG_FWD_BIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CONFIG,
    FILL,
    DRAIN
  } state_t;

  // Number of real samples in one frame of length 2^nfft.
  function automatic logic [31:0] frame_len(input logic [4:0] nfft);
    return 32'd1 << nfft;
  endfunction

  // Config channel word: forward transform flag plus log2 length.
  function automatic logic [15:0] cfg_word(input logic [4:0] nfft);
    logic [15:0] w;
    w              = '0;
    w[CFG_FWD_BIT] = 1'b1;
    w[4:0]         = nfft;
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Beat counter for one frame of samples. Flags the final beat of the
// frame and wraps back to zero when that beat is accepted.
module fft_frame_counter #(
  parameter int CNT_W = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             beat,
  input  logic [CNT_W-1:0] last_idx,
  output logic             is_last
);

  logic [CNT_W-1:0] count;

  assign is_last = (count == last_idx);

  // Advance on every accepted beat; the last beat of a frame restarts the count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (beat) begin
      count <= is_last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the audio stream for the FFT core: (re)configures the transform
// length between frames, passes exactly 2^nfft samples per frame with tlast
// on the final one, then waits for the FFT's output frame before starting
// again. A watchdog flags an FFT that never finishes its output frame.
module fft_frame_sequencer #(
  parameter int NFFT_MIN      = fft_pkg::NFFT_MIN,
  parameter int NFFT_MAX      = fft_pkg::NFFT_MAX,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int CNT_W         = 10
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [4:0]  req_nfft,
  input  logic [15:0] s_axis_audio_tdata,
  input  logic        s_axis_audio_tvalid,
  output logic        s_axis_audio_tready,
  output logic [31:0] m_axis_fft_data_tdata,
  output logic        m_axis_fft_data_tvalid,
  input  logic        m_axis_fft_data_tready,
  output logic        m_axis_fft_data_tlast,
  output logic [15:0] m_axis_fft_cfg_tdata,
  output logic        m_axis_fft_cfg_tvalid,
  input  logic        m_axis_fft_cfg_tready,
  input  logic        fft_out_tvalid,
  input  logic        fft_out_tlast,
  output logic [4:0]  curr_nfft,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        timeout_err
);

  import fft_pkg::*;

  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic               cfg_pending;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               req_legal;
  logic               need_cfg;
  logic               in_fill;
  logic               data_beat;
  logic               is_last;
  logic [CNT_W-1:0]   last_idx;
  logic               load_nfft;
  logic               cfg_done;
  logic               frame_done;
  logic               drain_expired;

  assign req_legal = (req_nfft >= 5'(NFFT_MIN)) && (req_nfft <= 5'(NFFT_MAX));
  assign need_cfg  = (req_legal && (req_nfft != curr_nfft)) || cfg_pending;

  assign in_fill   = (state_q == FILL);
  assign data_beat = in_fill && s_axis_audio_tvalid && m_axis_fft_data_tready;
  assign last_idx  = CNT_W'(frame_len(curr_nfft) - 32'd1);

  assign s_axis_audio_tready    = in_fill && m_axis_fft_data_tready;
  assign m_axis_fft_data_tvalid = in_fill && s_axis_audio_tvalid;
  assign m_axis_fft_data_tdata  = {16'h0000, s_axis_audio_tdata};
  assign m_axis_fft_data_tlast  = in_fill && is_last;
  assign m_axis_fft_cfg_tvalid  = (state_q == CONFIG);
  assign m_axis_fft_cfg_tdata   = cfg_word(curr_nfft);
  assign busy                   = (state_q != IDLE);

  fft_frame_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .beat     (data_beat),
    .last_idx (last_idx),
    .is_last  (is_last)
  );

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus single-cycle event strobes for the datapath registers.
  always_comb begin
    state_d       = state_q;
    load_nfft     = 1'b0;
    cfg_done      = 1'b0;
    frame_done    = 1'b0;
    drain_expired = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (need_cfg) begin
            load_nfft = 1'b1;
            state_d   = CONFIG;
          end else begin
            state_d = FILL;
          end
        end
      end
      CONFIG: begin
        if (m_axis_fft_cfg_tready) begin
          cfg_done = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (data_beat && is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fft_out_tvalid && fft_out_tlast) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else if (drain_cnt == DRAIN_LAST) begin
          drain_expired = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Active length only moves when leaving IDLE for CONFIG; illegal requests keep the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      curr_nfft   <= 5'(NFFT_MAX);
      cfg_pending <= 1'b1;
    end else begin
      if (load_nfft && req_legal) begin
        curr_nfft <= req_nfft;
      end
      if (cfg_done) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Watchdog on the FFT output frame; restarts every time DRAIN is entered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain_cnt <= '0;
    end else if (state_q == DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // Completed-frame counter and the sticky timeout flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drain_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer. A randomized audio source and
// FFT sink surround the DUT; a frame-level reference model predicts sample
// values, frame lengths, tlast placement, config words and frame counts.
module tb_fft_frame_sequencer;

  localparam int DRAIN_TIMEOUT = 4096;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [4:0]  req_nfft;
  logic [15:0] s_axis_audio_tdata;
  logic        s_axis_audio_tvalid;
  logic        s_axis_audio_tready;
  logic [31:0] m_axis_fft_data_tdata;
  logic        m_axis_fft_data_tvalid;
  logic        m_axis_fft_data_tready;
  logic        m_axis_fft_data_tlast;
  logic [15:0] m_axis_fft_cfg_tdata;
  logic        m_axis_fft_cfg_tvalid;
  logic        m_axis_fft_cfg_tready;
  logic        fft_out_tvalid;
  logic        fft_out_tlast;
  logic [4:0]  curr_nfft;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] cur_sample  = 16'h1234;
  int          model_next  = 10;
  int          model_active = 10;
  int          beat_idx    = 0;
  int          frames_seen = 0;
  int          cfg_beats   = 0;
  logic [15:0] last_cfg    = '0;
  logic        prev_cfg_wait = 1'b0;
  logic [15:0] prev_cfg_data = '0;
  logic        check_stall = 1'b0;
  int          frame_lens[$];

  // Stimulus controls
  logic accept_now = 1'b0;
  logic stall_mode = 1'b0;
  logic auto_fft   = 1'b1;
  int   fft_cd     = 0;

  fft_frame_sequencer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .enable                 (enable),
    .req_nfft               (req_nfft),
    .s_axis_audio_tdata     (s_axis_audio_tdata),
    .s_axis_audio_tvalid    (s_axis_audio_tvalid),
    .s_axis_audio_tready    (s_axis_audio_tready),
    .m_axis_fft_data_tdata  (m_axis_fft_data_tdata),
    .m_axis_fft_data_tvalid (m_axis_fft_data_tvalid),
    .m_axis_fft_data_tready (m_axis_fft_data_tready),
    .m_axis_fft_data_tlast  (m_axis_fft_data_tlast),
    .m_axis_fft_cfg_tdata   (m_axis_fft_cfg_tdata),
    .m_axis_fft_cfg_tvalid  (m_axis_fft_cfg_tvalid),
    .m_axis_fft_cfg_tready  (m_axis_fft_cfg_tready),
    .fft_out_tvalid         (fft_out_tvalid),
    .fft_out_tlast          (fft_out_tlast),
    .curr_nfft              (curr_nfft),
    .busy                   (busy),
    .frame_cnt              (frame_cnt),
    .timeout_err            (timeout_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives source valid/data, sink readies and the emulated FFT output pulse.
  task automatic applyStimulus();
    if (accept_now) begin
      cur_sample = 16'($urandom);
    end
    if (accept_now || !s_axis_audio_tvalid) begin
      s_axis_audio_tvalid = !stall_mode || ($urandom_range(0, 3) != 0);
    end
    s_axis_audio_tdata     = cur_sample;
    m_axis_fft_data_tready = !stall_mode || ($urandom_range(0, 2) != 0);
    m_axis_fft_cfg_tready  = !stall_mode || ($urandom_range(0, 1) != 0);
    fft_out_tvalid = 1'b0;
    fft_out_tlast  = 1'b0;
    if (fft_cd > 0) begin
      fft_cd--;
      if (fft_cd == 0) begin
        fft_out_tvalid = 1'b1;
        fft_out_tlast  = 1'b1;
      end
    end
  endtask

  // Observes handshakes at the falling edge and checks them against the model.
  task automatic monitorBeats();
    if (!aresetn) begin
      beat_idx      = 0;
      accept_now    = 1'b0;
      fft_cd        = 0;
      check_stall   = 1'b0;
      prev_cfg_wait = 1'b0;
      return;
    end
    accept_now = s_axis_audio_tvalid && s_axis_audio_tready;
    if (check_stall) begin
      checkOutput("stall_after_tlast", 32'(s_axis_audio_tready), 32'd0);
      check_stall = 1'b0;
    end
    if (m_axis_fft_cfg_tvalid === 1'b1) begin
      if (prev_cfg_wait) begin
        checkOutput("cfg_stable", 32'(m_axis_fft_cfg_tdata), 32'(prev_cfg_data));
      end
      prev_cfg_data = m_axis_fft_cfg_tdata;
      prev_cfg_wait = !m_axis_fft_cfg_tready;
      if (m_axis_fft_cfg_tready) begin
        cfg_beats++;
        last_cfg = m_axis_fft_cfg_tdata;
      end
    end else begin
      prev_cfg_wait = 1'b0;
    end
    if (m_axis_fft_data_tvalid === 1'b1 && m_axis_fft_data_tready) begin
      if (beat_idx == 0) model_active = model_next;
      checkOutput("data", m_axis_fft_data_tdata, {16'h0000, cur_sample});
      checkOutput("src_ready", 32'(s_axis_audio_tready), 32'd1);
      checkOutput("curr_nfft_frame", 32'(curr_nfft), 32'(model_active));
      checkOutput("tlast", 32'(m_axis_fft_data_tlast),
                  32'(beat_idx == (1 << model_active) - 1));
      if (m_axis_fft_data_tlast) begin
        frame_lens.push_back(beat_idx + 1);
        beat_idx    = 0;
        frames_seen++;
        check_stall = 1'b1;
        if (auto_fft) fft_cd = 5 + int'($urandom_range(0, 9));
      end else begin
        beat_idx++;
      end
    end
  endtask

  always @(negedge aclk) monitorBeats();

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      applyStimulus();
    end
  end

  task automatic waitFrames(input int n, input int budget);
    int c = 0;
    while (frames_seen < n && c < budget) begin
      @(negedge aclk);
      c++;
    end
    checkOutput("frames_reached", 32'(frames_seen), 32'(n));
  endtask

  task automatic waitBeat(input int k, input int budget);
    int c = 0;
    while (beat_idx < k && c < budget) begin
      @(negedge aclk);
      c++;
    end
    checkOutput("beat_reached", 32'(beat_idx >= k), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    @(negedge aclk);
    while (busy !== 1'b0 && c < budget) begin
      @(negedge aclk);
      c++;
    end
    checkOutput("parked_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkFrameLen(input string tag, input int exp);
    int got = -1;
    if (frame_lens.size() > 0) got = frame_lens.pop_front();
    checkOutput(tag, 32'(got), 32'(exp));
  endtask

  task automatic checkResetState();
    checkOutput("rst_curr_nfft", 32'(curr_nfft), 32'd10);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_audio_tready", 32'(s_axis_audio_tready), 32'd0);
    checkOutput("rst_data_tvalid", 32'(m_axis_fft_data_tvalid), 32'd0);
    checkOutput("rst_data_tlast", 32'(m_axis_fft_data_tlast), 32'd0);
    checkOutput("rst_cfg_tvalid", 32'(m_axis_fft_cfg_tvalid), 32'd0);
  endtask

  // Hard stop in case something upstream of the bounded waits goes wrong.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    int cfg_snap;
    int c;
    aresetn             = 1'b0;
    enable              = 1'b0;
    req_nfft            = 5'd10;
    s_axis_audio_tvalid = 1'b0;
    s_axis_audio_tdata  = '0;
    m_axis_fft_data_tready = 1'b1;
    m_axis_fft_cfg_tready  = 1'b1;
    fft_out_tvalid      = 1'b0;
    fft_out_tlast       = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge aclk);
    checkResetState();
    @(posedge aclk); #3;
    aresetn = 1'b1;

    $display("[TB] first frame at nfft=10");
    enable = 1'b1;
    waitFrames(1, 3000);
    checkOutput("cfg_count_first", 32'(cfg_beats), 32'd1);
    checkOutput("cfg_word_first", 32'(last_cfg), 32'h010A);
    checkFrameLen("frame1_len", 1024);
    checkOutput("curr_nfft_10", 32'(curr_nfft), 32'd10);

    $display("[TB] length change to 8 mid-frame");
    waitBeat(100, 2000);
    req_nfft   = 5'd8;
    model_next = 8;
    waitFrames(2, 3000);
    checkOutput("cfg_skipped_b2b", 32'(cfg_beats), 32'd1);
    checkFrameLen("frame2_len", 1024);
    waitFrames(3, 2000);
    checkOutput("cfg_count_8", 32'(cfg_beats), 32'd2);
    checkOutput("cfg_word_8", 32'(last_cfg), 32'h0108);
    checkFrameLen("frame3_len", 256);
    checkOutput("curr_nfft_8", 32'(curr_nfft), 32'd8);

    $display("[TB] illegal requests under random stalls");
    stall_mode = 1'b1;
    waitBeat(20, 2000);
    req_nfft = 5'd12;
    waitFrames(4, 3000);
    checkFrameLen("frame4_len", 256);
    waitBeat(20, 2000);
    req_nfft = 5'd5;
    waitFrames(5, 3000);
    checkFrameLen("frame5_len", 256);
    waitFrames(6, 3000);
    checkFrameLen("frame6_len", 256);
    checkOutput("cfg_count_illegal", 32'(cfg_beats), 32'd2);
    checkOutput("curr_nfft_kept", 32'(curr_nfft), 32'd8);

    $display("[TB] disable mid-frame and park");
    waitBeat(50, 2000);
    enable = 1'b0;
    waitIdle(3000);
    checkOutput("park_frames", 32'(frames_seen), 32'd7);
    checkFrameLen("frame7_len", 256);
    checkOutput("park_frame_cnt", 32'(frame_cnt), 32'd7);
    repeat (5) @(negedge aclk);
    checkOutput("park_busy", 32'(busy), 32'd0);
    checkOutput("park_audio_tready", 32'(s_axis_audio_tready), 32'd0);
    checkOutput("park_data_tvalid", 32'(m_axis_fft_data_tvalid), 32'd0);
    fft_cd = 2;
    repeat (6) @(negedge aclk);
    checkOutput("stray_tlast_ignored", 32'(frame_cnt), 32'd7);

    $display("[TB] drain timeout");
    stall_mode = 1'b0;
    auto_fft   = 1'b0;
    enable     = 1'b1;
    waitFrames(8, 2000);
    enable = 1'b0;
    checkFrameLen("frame8_len", 256);
    repeat (DRAIN_TIMEOUT - 50) @(negedge aclk);
    checkOutput("timeout_not_yet", 32'(timeout_err), 32'd0);
    checkOutput("still_draining", 32'(busy), 32'd1);
    c = 0;
    while (timeout_err !== 1'b1 && c < 200) begin
      @(negedge aclk);
      c++;
    end
    checkOutput("timeout_set", 32'(timeout_err), 32'd1);
    waitIdle(20);
    checkOutput("timeout_frame_cnt", 32'(frame_cnt), 32'd7);

    $display("[TB] reset mid-frame then three frames");
    auto_fft   = 1'b1;
    req_nfft   = 5'd10;
    model_next = 10;
    enable     = 1'b1;
    waitBeat(30, 2000);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checkResetState();
    cfg_snap = cfg_beats;
    @(posedge aclk); #3;
    aresetn = 1'b1;
    waitFrames(9, 3000);
    checkOutput("cfg_after_reset", 32'(cfg_beats), 32'(cfg_snap + 1));
    checkOutput("cfg_word_reset", 32'(last_cfg), 32'h010A);
    checkFrameLen("frame9_len", 1024);
    waitFrames(11, 5000);
    enable = 1'b0;
    waitIdle(200);
    checkFrameLen("frame10_len", 1024);
    checkFrameLen("frame11_len", 1024);
    checkOutput("frame_cnt_three", 32'(frame_cnt), 32'd3);
    checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
